// File: rtl/icache_axi_rd_bridge.sv
// icache refill responder: turns one cache read request into a single AXI4
// read burst (8x32b INCR for a line, 1x32b for an uncached word), packs the
// R beats into a 256b line and returns it with a one-cycle ret_valid pulse.
module icache_axi_rd_bridge #(
   parameter int ID_W   = 4,
   parameter int AXI_ID = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rd_req,
   input  logic            rd_type,
   input  logic [31:0]     rd_addr,
   output logic            rd_rdy,
   output logic            ret_valid,
   output logic [255:0]    ret_data,
   output logic            proto_err,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_AR   = 4'b0010,
      S_R    = 4'b0100,
      S_DONE = 4'b1000
   } state_e;

   state_e         state_q, state_d;
   logic [31:0]    addr_q;
   logic           type_q;
   logic [255:0]   data_q;
   logic [7:0]     cnt_q;
   logic           perr_q;
   logic           beat;
   logic           unused_rresp;

   // Response status carries no information this bridge acts on.
   assign unused_rresp = ^rresp;

   assign beat      = (state_q == S_R) && rvalid;
   assign rd_rdy    = (state_q == S_IDLE);
   assign arvalid   = (state_q == S_AR);
   assign rready    = (state_q == S_R);
   assign ret_valid = (state_q == S_DONE);
   assign ret_data  = data_q;
   assign proto_err = perr_q;
   assign arid      = ID_W'(AXI_ID);
   assign araddr    = addr_q;
   assign arlen     = type_q ? 8'd7 : 8'd0;
   assign arsize    = 3'b010;
   assign arburst   = 2'b01;

   // State register; reset drops any burst in flight immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state: one request at a time, R phase ends only on rlast.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (rd_req)         state_d = S_AR;
         S_AR:    if (arready)        state_d = S_R;
         S_R:     if (rvalid && rlast) state_d = S_DONE;
         S_DONE:                      state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // Request latch, beat packing, beat counter and sticky protocol error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         type_q <= 1'b0;
         data_q <= '0;
         cnt_q  <= '0;
         perr_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && rd_req) begin
            addr_q <= rd_addr;
            type_q <= rd_type;
         end
         if (beat) begin
            // Line beats shift in from the top so beat k ends at word k.
            if (type_q) data_q <= {rdata, data_q[255:32]};
            else        data_q[31:0] <= rdata;
            cnt_q <= cnt_q + 8'd1;
            if ((rlast && cnt_q != arlen) || (!rlast && cnt_q == arlen) ||
                (rid != arid))
               perr_q <= 1'b1;
         end
         if (state_q == S_DONE) cnt_q <= '0;
      end
   end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: drives an AXI read slave by hand
// and checks the returned line against a small packing model.
module tb_icache_axi_rd_bridge;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_req, rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy, ret_valid, proto_err;
   logic [255:0] ret_data;
   logic [3:0]   arid, rid;
   logic [31:0]  araddr, rdata;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst, rresp;
   logic         arvalid, arready, rlast, rvalid, rready;

   int total = 0;
   int bad   = 0;
   logic [255:0] exp_line;

   icache_axi_rd_bridge #(.ID_W(4), .AXI_ID(0)) dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .rd_type(rd_type),
      .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
      .ret_data(ret_data), .proto_err(proto_err), .arid(arid),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here.
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete request: ar_wait cycles of arready low, gap idle cycles
   // before every R beat, nbeats beats (rlast on the final one).
   task automatic xfer(input bit typ, input logic [31:0] addr, input int ar_wait,
                       input int gap, input int nbeats, input logic [31:0] base,
                       input bit keep_req, input bit bad_rid);
      rd_req = 1'b1; rd_type = typ; rd_addr = addr;
      chk("rdy_idle", rd_rdy, 1);
      tick();
      if (!keep_req) rd_req = 1'b0;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, typ ? 8'd7 : 8'd0);
      chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, 2'b01);
      chk("arid", arid, 0);
      chk("rdy_busy", rd_rdy, 0);
      for (int i = 0; i < ar_wait; i++) begin
         tick();
         chk("ar_hold_v", arvalid, 1);
         chk("ar_hold_a", araddr, addr);
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("ar_drop", arvalid, 0);
      for (int b = 0; b < nbeats; b++) begin
         for (int g = 0; g < gap; g++) tick();
         rvalid = 1'b1; rdata = base + b; rlast = (b == nbeats - 1);
         rid = bad_rid ? 4'd1 : 4'd0;
         chk("rready", rready, 1);
         chk("no_ar_in_r", arvalid, 0);
         if (typ) exp_line = {base + b, exp_line[255:32]};
         else     exp_line[31:0] = base + b;
         tick();
         rvalid = 1'b0; rlast = 1'b0; rid = 4'd0;
      end
      chk("ret_valid", ret_valid, 1);
      chk("done_noar", arvalid, 0);
      if (typ) chk("ret_line", ret_data, exp_line);
      else     chk("ret_word", ret_data[31:0], exp_line[31:0]);
      tick();
      chk("ret_pulse", ret_valid, 0);
      chk("rdy_back", rd_rdy, 1);
      chk("ret_hold", ret_data[31:0], exp_line[31:0]);
   endtask

   initial begin
      rd_req = 0; rd_type = 0; rd_addr = '0; arready = 0; rid = '0;
      rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
      exp_line = '0;
      reset = 1'b1;
      tick(); tick();
      chk("rst_rdy", rd_rdy, 1);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_retv", ret_valid, 0);
      chk("rst_data", ret_data, '0);
      chk("rst_perr", proto_err, 0);
      reset = 1'b0;
      tick();

      // 1: line, zero-wait, beats 0..7
      xfer(1, 32'h1FC0_0020, 0, 0, 8, 32'd0, 0, 0);
      chk("t1_w0", ret_data[31:0], 32'd0);
      chk("t1_w7", ret_data[255:224], 32'd7);
      chk("t1_perr", proto_err, 0);

      // 2: single uncached word
      xfer(0, 32'hBFAF_8004, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
      chk("t2_word", ret_data[31:0], 32'hDEAD_BEEF);
      chk("t2_perr", proto_err, 0);

      // 3: AR backpressure plus R gaps
      xfer(1, 32'h0000_1040, 5, 2, 8, 32'hA5A5_0000, 0, 0);
      chk("t3_w3", ret_data[127:96], 32'hA5A5_0003);
      chk("t3_perr", proto_err, 0);

      // 4: rlast arrives on beat 4 of a line
      xfer(1, 32'h0000_2000, 0, 0, 4, 32'h0000_0010, 0, 0);
      chk("t4_perr", proto_err, 1);
      tick();
      chk("t4_sticky", proto_err, 1);

      // 5: rd_req held high; exactly one new AR after returning to IDLE
      xfer(1, 32'h0000_3000, 0, 0, 8, 32'h5000_0000, 1, 0);
      xfer(0, 32'h0000_3000, 0, 0, 1, 32'h6000_0000, 0, 0);
      tick();
      chk("t5_one_ar", arvalid, 0);
      chk("t5_perr", proto_err, 1);

      // 6: reset on the third beat of a line
      rd_req = 1; rd_type = 1; rd_addr = 32'h0000_4000;
      tick();
      rd_req = 0; arready = 1;
      tick();
      arready = 0;
      for (int b = 0; b < 2; b++) begin
         rvalid = 1; rdata = 32'h7000_0000 + b;
         tick();
      end
      rdata = 32'h7000_0002;
      reset = 1'b1;
      #1;
      chk("t6_arvalid", arvalid, 0);
      chk("t6_rready", rready, 0);
      chk("t6_retv", ret_valid, 0);
      chk("t6_rdy", rd_rdy, 1);
      chk("t6_perr", proto_err, 0);
      chk("t6_data", ret_data, '0);
      tick();
      reset = 1'b0;
      rlast = 1;
      tick();
      chk("t6_stray_rr", rready, 0);
      chk("t6_stray_rv", ret_valid, 0);
      chk("t6_stray_dat", ret_data, '0);
      rvalid = 0; rlast = 0;
      tick();

      // rid mismatch on a single-word read flags proto_err
      exp_line = '0;
      xfer(0, 32'h0000_5004, 0, 1, 1, 32'h1234_5678, 0, 1);
      chk("rid_perr", proto_err, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
